// File: rtl/dc_line_seq_pkg.sv
// Shared definitions for the data-cache line sequencer.
package dc_pkg;

    localparam int LINE_W = 128;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WB_RD     = 3'd1,
        S_WB_CAP    = 3'd2,
        S_WB_REQ    = 3'd3,
        S_FILL_REQ  = 3'd4,
        S_FILL_WAIT = 3'd5,
        S_FILL_WR   = 3'd6,
        S_DONE      = 3'd7
    } state_t;

endpackage

// File: rtl/dc_line_seq_tmo_cnt.sv
// Clearable saturating wait counter; o_hit marks the TMO-th enabled cycle.
module dc_tmo_cnt #(
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam int CW = $clog2(TMO + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && r_cnt != CW'(TMO)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Count holds the number of cycles already spent, so TMO-1 means this is the last allowed one.
    assign o_hit = i_en && (r_cnt == CW'(TMO - 1));

endmodule

// File: rtl/dc_line_seq.sv
// Whole-line writeback/fill sequencer between the MA data RAM line port and DRAM.
module dc_line_seq
    import dc_pkg::*;
#(
    parameter int DWIDTH = 11,
    parameter int LWIDTH = 23,
    parameter int TMO    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_start,
    input  logic              req_wb,
    input  logic              req_fill,
    input  logic [DWIDTH-3:0] req_index,
    input  logic [LWIDTH-1:0] req_wb_adr,
    input  logic [LWIDTH-1:0] req_fill_adr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DWIDTH-3:0] ram_radr_all,
    output logic              ram_ren_all,
    input  logic [LINE_W-1:0] ram_rdata_all,
    output logic [DWIDTH-3:0] ram_wadr_all,
    output logic [LINE_W-1:0] ram_wdata_all,
    output logic              ram_wen_all,
    output logic              dram_wreq,
    output logic [LWIDTH-1:0] dram_wadr,
    output logic [LINE_W-1:0] dram_wdata,
    input  logic              dram_wack,
    output logic              dram_rreq,
    output logic [LWIDTH-1:0] dram_radr,
    input  logic              dram_rack,
    input  logic              dram_rvalid,
    input  logic [LINE_W-1:0] dram_rdata
);

    state_t              r_state;
    logic                r_fill;
    logic                r_err;
    logic [DWIDTH-3:0]   r_index;
    logic [LWIDTH-1:0]   r_wb_adr;
    logic [LWIDTH-1:0]   r_fill_adr;
    logic [LINE_W-1:0]   r_buf;

    logic w_wait;
    logic w_chg;
    logic w_hit;

    assign w_wait = (r_state == S_WB_REQ) || (r_state == S_FILL_REQ) || (r_state == S_FILL_WAIT);

    // Mirrors the FSM's exit conditions so the counter restarts from zero in every new state.
    always_comb begin
        w_chg = 1'b1;
        case (r_state)
            S_IDLE:      w_chg = req_start;
            S_WB_REQ:    w_chg = dram_wack | w_hit;
            S_FILL_REQ:  w_chg = dram_rack | w_hit;
            S_FILL_WAIT: w_chg = dram_rvalid | w_hit;
            default:     w_chg = 1'b1;
        endcase
    end

    dc_tmo_cnt #(.TMO(TMO)) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_chg),
        .i_en  (w_wait),
        .o_hit (w_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fill     <= 1'b0;
            r_err      <= 1'b0;
            r_index    <= '0;
            r_wb_adr   <= '0;
            r_fill_adr <= '0;
            r_buf      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_start) begin
                        r_fill     <= req_fill;
                        r_index    <= req_index;
                        r_wb_adr   <= req_wb_adr;
                        r_fill_adr <= req_fill_adr;
                        r_state    <= req_wb ? S_WB_RD : (req_fill ? S_FILL_REQ : S_DONE);
                    end
                end
                S_WB_RD:  r_state <= S_WB_CAP;
                S_WB_CAP: begin
                    r_buf   <= ram_rdata_all;
                    r_state <= S_WB_REQ;
                end
                S_WB_REQ: begin
                    if (dram_wack) begin
                        r_state <= r_fill ? S_FILL_REQ : S_DONE;
                    end else if (w_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_FILL_REQ: begin
                    if (dram_rack) begin
                        r_state <= S_FILL_WAIT;
                    end else if (w_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_FILL_WAIT: begin
                    // Data arriving on the last allowed cycle still wins over the abort.
                    if (dram_rvalid) begin
                        r_buf   <= dram_rdata;
                        r_state <= S_FILL_WR;
                    end else if (w_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_FILL_WR: r_state <= S_DONE;
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign err           = r_err;
    assign ram_ren_all   = (r_state == S_WB_RD);
    assign ram_wen_all   = (r_state == S_FILL_WR);
    assign dram_wreq     = (r_state == S_WB_REQ);
    assign dram_rreq     = (r_state == S_FILL_REQ);
    assign ram_radr_all  = r_index;
    assign ram_wadr_all  = r_index;
    assign ram_wdata_all = r_buf;
    assign dram_wadr     = r_wb_adr;
    assign dram_wdata    = r_buf;
    assign dram_radr     = r_fill_adr;

endmodule

// File: tb/tb_dc_line_seq.sv
// Randomised bench for dc_line_seq with a RAM/DRAM environment and a line-level reference model.
module tb_dc_line_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_start = 1'b0, req_wb = 1'b0, req_fill = 1'b0;
    logic [8:0]   req_index = '0;
    logic [22:0]  req_wb_adr = '0, req_fill_adr = '0;
    logic         busy, done, err;
    logic [8:0]   ram_radr_all, ram_wadr_all;
    logic         ram_ren_all, ram_wen_all;
    logic [127:0] ram_rdata_all = '0;
    logic [127:0] ram_wdata_all;
    logic         dram_wreq, dram_rreq;
    logic [22:0]  dram_wadr, dram_radr;
    logic [127:0] dram_wdata;
    logic         dram_wack = 1'b0, dram_rack = 1'b0, dram_rvalid = 1'b0;
    logic [127:0] dram_rdata = '0;

    always #5 clk = ~clk;

    dc_line_seq dut (
        .clk(clk), .rst_n(rst_n), .req_start(req_start), .req_wb(req_wb), .req_fill(req_fill),
        .req_index(req_index), .req_wb_adr(req_wb_adr), .req_fill_adr(req_fill_adr),
        .busy(busy), .done(done), .err(err),
        .ram_radr_all(ram_radr_all), .ram_ren_all(ram_ren_all), .ram_rdata_all(ram_rdata_all),
        .ram_wadr_all(ram_wadr_all), .ram_wdata_all(ram_wdata_all), .ram_wen_all(ram_wen_all),
        .dram_wreq(dram_wreq), .dram_wadr(dram_wadr), .dram_wdata(dram_wdata), .dram_wack(dram_wack),
        .dram_rreq(dram_rreq), .dram_radr(dram_radr), .dram_rack(dram_rack),
        .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical data RAM: 1-cycle read latency, plus a backdoor for preloading lines.
    logic [127:0] mem [512];
    logic         bd_we = 1'b0;
    logic [8:0]   bd_adr = '0;
    logic [127:0] bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) mem[bd_adr] <= bd_data;
        if (ram_wen_all) mem[ram_wadr_all] <= ram_wdata_all;
        if (ram_ren_all) ram_rdata_all <= mem[ram_radr_all];
    end

    // Cumulative event monitor; tests work with deltas.
    int n_wen = 0, n_ren = 0, n_wreq = 0, n_rreq = 0, n_done = 0, n_err = 0, n_err_alone = 0;
    logic [8:0]   m_wen_adr = '0;
    logic [127:0] m_wen_data = '0;
    always @(negedge clk) begin
        if (ram_wen_all) begin n_wen++; m_wen_adr = ram_wadr_all; m_wen_data = ram_wdata_all; end
        if (ram_ren_all) n_ren++;
        if (dram_wreq) n_wreq++;
        if (dram_rreq) n_rreq++;
        if (done) n_done++;
        if (err) n_err++;
        if (err && !done) n_err_alone++;
    end

    // Reference model of data RAM contents.
    logic [127:0] ref_mem [512];

    // Per-sequence observations.
    int d_wen, d_ren, d_wreq, d_rreq, d_done, d_err, d_err_alone;
    int start_cyc, wack_cyc, rack_cyc, rvalid_cyc, d_cyc;
    bit got_done, busy_at1, busy_after, err_at_done;
    logic [22:0]  o_wadr, o_radr;
    logic [127:0] o_wdata;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic preload(input logic [8:0] idx, input logic [127:0] data);
        bd_adr = idx; bd_data = data; bd_we = 1'b1;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    // Issues one request and plays the DRAM side with the given latencies.
    task automatic run_seq(input bit wb, input bit fill, input logic [8:0] idx,
                           input logic [22:0] wa, input logic [22:0] fa,
                           input int wl, input int rl, input int vl,
                           input logic [127:0] rd, input bit give_valid, input bit poke);
        int wc, rc, vc, b_wen, b_ren, b_wreq, b_rreq, b_done, b_err, b_alone;
        bit in_wait;
        b_wen = n_wen; b_ren = n_ren; b_wreq = n_wreq; b_rreq = n_rreq;
        b_done = n_done; b_err = n_err; b_alone = n_err_alone;
        wack_cyc = -1; rack_cyc = -1; rvalid_cyc = -1; d_cyc = -1;
        got_done = 0; err_at_done = 0;
        o_wadr = '0; o_radr = '0; o_wdata = '0;
        req_wb = wb; req_fill = fill; req_index = idx; req_wb_adr = wa; req_fill_adr = fa;
        req_start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        req_start = 1'b0;
        req_wb = 1'($urandom); req_fill = 1'($urandom); req_index = 9'($urandom);
        req_wb_adr = 23'($urandom); req_fill_adr = 23'($urandom);
        busy_at1 = busy;
        wc = 0; rc = 0; vc = 0; in_wait = 0;
        for (int c = 0; c < 2000; c++) begin
            dram_wack = 1'b0; dram_rack = 1'b0; dram_rvalid = 1'b0;
            dram_rdata = rnd128();
            if (poke && c == 1) begin
                req_start = 1'b1; req_wb = 1'b1; req_fill = 1'b1;
                req_index = ~idx; req_wb_adr = ~wa; req_fill_adr = ~fa;
            end else begin
                req_start = 1'b0;
            end
            if (done) begin
                got_done = 1; d_cyc = cyc; err_at_done = err;
                break;
            end
            if (dram_wreq) begin
                if (wc == wl) begin
                    dram_wack = 1'b1; o_wadr = dram_wadr; o_wdata = dram_wdata; wack_cyc = cyc;
                end
                wc++;
            end
            if (dram_rreq) begin
                if (rc == rl) begin
                    dram_rack = 1'b1; o_radr = dram_radr; rack_cyc = cyc; in_wait = 1; vc = 0;
                end
                rc++;
            end else if (in_wait && busy) begin
                if (give_valid && vc == vl) begin
                    dram_rvalid = 1'b1; dram_rdata = rd; rvalid_cyc = cyc; in_wait = 0;
                end
                vc++;
            end
            @(posedge clk); #1;
        end
        dram_wack = 1'b0; dram_rack = 1'b0; dram_rvalid = 1'b0; req_start = 1'b0;
        @(posedge clk); #1;
        busy_after = busy;
        d_wen = n_wen - b_wen; d_ren = n_ren - b_ren; d_wreq = n_wreq - b_wreq;
        d_rreq = n_rreq - b_rreq; d_done = n_done - b_done; d_err = n_err - b_err;
        d_err_alone = n_err_alone - b_alone;
        checks++;
        if (got_done !== 1'b1) begin
            errors++; $display("FAIL seq_done_within_bound: got %0b expected 1", got_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rst_status: got %b expected 000", {busy, done, err}); end
        checks++; if ({ram_ren_all, ram_wen_all, dram_wreq, dram_rreq} !== 4'b0) begin errors++; $display("FAIL rst_strobes: got %b expected 0000", {ram_ren_all, ram_wen_all, dram_wreq, dram_rreq}); end
        checks++; if ({ram_radr_all, ram_wadr_all, dram_wadr, dram_radr} !== '0) begin errors++; $display("FAIL rst_addrs: got %h expected 0", {ram_radr_all, ram_wadr_all, dram_wadr, dram_radr}); end
        checks++; if ({ram_wdata_all, dram_wdata} !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", {ram_wdata_all, dram_wdata}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_fill_only();
        logic [127:0] d;
        d = 128'h0F0E0D0C0B0A09080706050403020100;
        preload(9'h05, rnd128());
        run_seq(1'b0, 1'b1, 9'h05, 23'h0, 23'h000123, 0, 2, 2, d, 1'b1, 1'b0);
        checks++; if (d_wen !== 1) begin errors++; $display("FAIL fill_wen_count: got %0d expected 1", d_wen); end
        checks++; if (m_wen_adr !== 9'h05) begin errors++; $display("FAIL fill_wen_adr: got %h expected 005", m_wen_adr); end
        checks++; if (m_wen_data !== d) begin errors++; $display("FAIL fill_wen_data: got %h expected %h", m_wen_data, d); end
        checks++; if (o_radr !== 23'h000123) begin errors++; $display("FAIL fill_radr: got %h expected 000123", o_radr); end
        checks++; if (d_wreq !== 0) begin errors++; $display("FAIL fill_no_wreq: got %0d expected 0", d_wreq); end
        checks++; if (d_done !== 1 || d_err !== 0) begin errors++; $display("FAIL fill_done_err: got done=%0d err=%0d expected 1/0", d_done, d_err); end
        checks++; if (d_cyc !== rvalid_cyc + 2) begin errors++; $display("FAIL fill_latency: got %0d expected %0d", d_cyc, rvalid_cyc + 2); end
        checks++; if (busy_at1 !== 1'b1 || busy_after !== 1'b0) begin errors++; $display("FAIL fill_busy: got rise=%b after=%b expected 1/0", busy_at1, busy_after); end
        checks++; if (mem[5] !== d) begin errors++; $display("FAIL fill_ram_line: got %h expected %h", mem[5], d); end
        ref_mem[5] = d;
    endtask

    task automatic test_wb_fill();
        logic [127:0] pre, d;
        pre = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        d = rnd128();
        preload(9'h07, pre);
        run_seq(1'b1, 1'b1, 9'h07, 23'h000040, 23'h1ABCDE, 1, 0, 1, d, 1'b1, 1'b0);
        checks++; if (o_wdata !== pre) begin errors++; $display("FAIL wbf_wdata: got %h expected %h", o_wdata, pre); end
        checks++; if (o_wdata[127:96] !== 32'hDEADBEEF) begin errors++; $display("FAIL wbf_word3: got %h expected deadbeef", o_wdata[127:96]); end
        checks++; if (o_wadr !== 23'h000040) begin errors++; $display("FAIL wbf_wadr: got %h expected 000040", o_wadr); end
        checks++; if (d_ren !== 1 || d_wen !== 1) begin errors++; $display("FAIL wbf_strobes: got ren=%0d wen=%0d expected 1/1", d_ren, d_wen); end
        checks++; if (mem[7] !== d) begin errors++; $display("FAIL wbf_ram_line: got %h expected %h", mem[7], d); end
        ref_mem[7] = d;
    endtask

    task automatic test_wb_only();
        preload(9'h1F0, rnd128());
        run_seq(1'b1, 1'b0, 9'h1F0, 23'h7FFFFF, 23'h0, 3, 0, 0, '0, 1'b1, 1'b0);
        checks++; if (d_rreq !== 0 || d_wen !== 0) begin errors++; $display("FAIL wbo_no_fill: got rreq=%0d wen=%0d expected 0/0", d_rreq, d_wen); end
        checks++; if (d_cyc !== wack_cyc + 1) begin errors++; $display("FAIL wbo_done_after_ack: got %0d expected %0d", d_cyc, wack_cyc + 1); end
        checks++; if (o_wdata !== ref_mem[9'h1F0]) begin errors++; $display("FAIL wbo_wdata: got %h expected %h", o_wdata, ref_mem[9'h1F0]); end
        checks++; if (d_done !== 1) begin errors++; $display("FAIL wbo_done_count: got %0d expected 1", d_done); end
    endtask

    task automatic test_empty();
        run_seq(1'b0, 1'b0, 9'h0AA, 23'h1, 23'h2, 0, 0, 0, '0, 1'b1, 1'b0);
        checks++; if (d_cyc !== start_cyc + 1) begin errors++; $display("FAIL empty_latency: got %0d expected %0d", d_cyc, start_cyc + 1); end
        checks++; if (busy_at1 !== 1'b1 || busy_after !== 1'b0) begin errors++; $display("FAIL empty_busy: got rise=%b after=%b expected 1/0", busy_at1, busy_after); end
        checks++; if (d_done !== 1 || d_err !== 0) begin errors++; $display("FAIL empty_done_err: got done=%0d err=%0d expected 1/0", d_done, d_err); end
        checks++; if (d_ren + d_wen + d_wreq + d_rreq !== 0) begin errors++; $display("FAIL empty_no_traffic: got %0d expected 0", d_ren + d_wen + d_wreq + d_rreq); end
    endtask

    task automatic test_timeout();
        logic [127:0] d;
        preload(9'h033, rnd128());
        run_seq(1'b0, 1'b1, 9'h033, 23'h0, 23'h000777, 0, 1, 0, rnd128(), 1'b0, 1'b0);
        checks++; if (d_cyc - rack_cyc !== 256) begin errors++; $display("FAIL tmo_latency: got %0d expected 256", d_cyc - rack_cyc); end
        checks++; if (err_at_done !== 1'b1 || d_err !== 1 || d_err_alone !== 0) begin errors++; $display("FAIL tmo_err: got at_done=%b n=%0d alone=%0d expected 1/1/0", err_at_done, d_err, d_err_alone); end
        checks++; if (d_wen !== 0) begin errors++; $display("FAIL tmo_no_wen: got %0d expected 0", d_wen); end
        checks++; if (mem[9'h033] !== ref_mem[9'h033]) begin errors++; $display("FAIL tmo_ram_intact: got %h expected %h", mem[9'h033], ref_mem[9'h033]); end
        d = rnd128();
        run_seq(1'b0, 1'b1, 9'h033, 23'h0, 23'h000778, 0, 0, 0, d, 1'b1, 1'b0);
        ref_mem[9'h033] = d;
        checks++; if (d_err !== 0 || mem[9'h033] !== d) begin errors++; $display("FAIL tmo_recover: got err=%0d line=%h expected 0 %h", d_err, mem[9'h033], d); end
    endtask

    task automatic test_reset_midseq();
        int b_wen;
        bit seen;
        preload(9'h044, rnd128());
        b_wen = n_wen;
        req_wb = 1'b0; req_fill = 1'b1; req_index = 9'h044; req_fill_adr = 23'h0ABCDE; req_start = 1'b1;
        @(posedge clk); #1;
        req_start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (dram_rreq) begin dram_rack = 1'b1; seen = 1; end
            @(posedge clk); #1;
            dram_rack = 1'b0;
        end
        checks++; if (!seen || busy !== 1'b1) begin errors++; $display("FAIL rstm_reach_wait: got seen=%b busy=%b expected 1/1", seen, busy); end
        #2 rst_n = 1'b0;
        dram_rvalid = 1'b1; dram_rdata = rnd128();
        #1;
        checks++; if ({busy, done, err, ram_wen_all, dram_rreq, dram_wreq} !== 6'b0) begin errors++; $display("FAIL rstm_outputs: got %b expected 000000", {busy, done, err, ram_wen_all, dram_rreq, dram_wreq}); end
        checks++; if (dram_radr !== 23'h0) begin errors++; $display("FAIL rstm_radr: got %h expected 0", dram_radr); end
        repeat (2) @(posedge clk);
        #1 dram_rvalid = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (n_wen - b_wen !== 0 || mem[9'h044] !== ref_mem[9'h044]) begin errors++; $display("FAIL rstm_no_write: got wen=%0d line=%h expected 0 %h", n_wen - b_wen, mem[9'h044], ref_mem[9'h044]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstm_idle: got %b expected 0", busy); end
    endtask

    task automatic test_start_while_busy();
        logic [127:0] d;
        d = rnd128();
        preload(9'h0C3, rnd128());
        run_seq(1'b0, 1'b1, 9'h0C3, 23'h0, 23'h055555, 0, 5, 0, d, 1'b1, 1'b1);
        ref_mem[9'h0C3] = d;
        checks++; if (o_radr !== 23'h055555) begin errors++; $display("FAIL swb_radr: got %h expected 055555", o_radr); end
        checks++; if (d_wen !== 1 || m_wen_adr !== 9'h0C3) begin errors++; $display("FAIL swb_wen: got n=%0d adr=%h expected 1 0c3", d_wen, m_wen_adr); end
        checks++; if (d_wreq !== 0 || d_done !== 1 || busy_after !== 1'b0) begin errors++; $display("FAIL swb_single_seq: got wreq=%0d done=%0d busy=%b expected 0/1/0", d_wreq, d_done, busy_after); end
    endtask

    task automatic test_random();
        bit wb, fill;
        logic [8:0] idx;
        logic [22:0] wa, fa;
        logic [127:0] d, old;
        for (int i = 0; i < 24; i++) begin
            wb = 1'($urandom); fill = 1'($urandom);
            idx = 9'($urandom); wa = 23'($urandom); fa = 23'($urandom);
            d = rnd128();
            preload(idx, rnd128());
            old = ref_mem[idx];
            run_seq(wb, fill, idx, wa, fa, $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 4), d, 1'b1, 1'b0);
            if (fill) ref_mem[idx] = d;
            checks++; if ((d_wreq > 0) !== wb || (d_ren == 1) !== wb) begin errors++; $display("FAIL rnd%0d_wb_traffic: got wreq=%0d ren=%0d expected wb=%0b", i, d_wreq, d_ren, wb); end
            checks++; if ((d_rreq > 0) !== fill || d_wen !== int'(fill)) begin errors++; $display("FAIL rnd%0d_fill_traffic: got rreq=%0d wen=%0d expected fill=%0b", i, d_rreq, d_wen, fill); end
            if (wb) begin
                checks++; if (o_wdata !== old || o_wadr !== wa) begin errors++; $display("FAIL rnd%0d_wb_data: got %h@%h expected %h@%h", i, o_wdata, o_wadr, old, wa); end
            end
            if (fill) begin
                checks++; if (o_radr !== fa) begin errors++; $display("FAIL rnd%0d_radr: got %h expected %h", i, o_radr, fa); end
            end
            checks++; if (mem[idx] !== ref_mem[idx]) begin errors++; $display("FAIL rnd%0d_ram_line: got %h expected %h", i, mem[idx], ref_mem[idx]); end
            checks++; if (d_done !== 1 || d_err !== 0 || busy_after !== 1'b0) begin errors++; $display("FAIL rnd%0d_done: got done=%0d err=%0d busy=%b expected 1/0/0", i, d_done, d_err, busy_after); end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill_only();
        test_wb_fill();
        test_wb_only();
        test_empty();
        test_random();
        test_start_while_busy();
        test_timeout();
        test_reset_midseq();
        test_empty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
